// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
// Imported by the ping-pong capture buffer and the controller.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    SETTLE,
    PRESENT
  } state_t;

  localparam int WIDTH_DEF     = 18;
  localparam int N_DEF         = 16;
  localparam int MAG_DELAY_DEF = 2;
  localparam int TIMEOUT_DEF   = 64;
  localparam int CNT_W         = 16;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_pingpong.sv
// Two-bank sample capture with lock/release for the FFT.
// Writes spill into the free bank on the fill-completion edge.
module sample_pingpong
  import fft_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sample_in,
  input  logic               sample_valid,
  input  logic               lock_i,
  input  logic               release_i,
  output logic               pending_o,
  output logic               drop_o,
  output logic [N*WIDTH-1:0] frame_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] bank_q [2][N];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       full_q, full_d;
  logic             lk_bank_q, lk_bank_d;
  logic             locked_q, locked_d;
  logic             wr_en;
  logic             last;

  // The effective write bank is the post-swap bank, so a sample
  // arriving on the swap cycle lands at index 0 of the new bank.
  always_comb begin
    wr_bank_d = wr_bank_q;
    if (full_q[wr_bank_q] && !full_q[~wr_bank_q])
      wr_bank_d = ~wr_bank_q;
    wr_en     = sample_valid && !full_q[wr_bank_d];
    drop_o    = sample_valid && !wr_en;
    last      = (wr_ptr_q == PW'(N-1));
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;
    locked_d  = locked_q;
    lk_bank_d = lk_bank_q;
    if (wr_en) begin
      wr_ptr_d = last ? '0 : wr_ptr_q + PW'(1);
      if (last)
        full_d[wr_bank_d] = 1'b1;
    end
    if (lock_i) begin
      locked_d  = 1'b1;
      lk_bank_d = ~wr_bank_q;
    end
    if (release_i) begin
      locked_d          = 1'b0;
      full_d[lk_bank_q] = 1'b0;
    end
  end

  assign pending_o = full_q[~wr_bank_q] && !locked_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      lk_bank_q <= 1'b0;
      locked_q  <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++)
          bank_q[b][i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      lk_bank_q <= lk_bank_d;
      locked_q  <= locked_d;
      if (wr_en)
        bank_q[wr_bank_d][wr_ptr_q] <= sample_in;
    end
  end

  always_comb begin
    frame_o = '0;
    for (int i = 0; i < N; i++)
      frame_o[i*WIDTH +: WIDTH] = bank_q[lk_bank_q][i];
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: locks captured frames, drives the FFT,
// and hands registered magnitudes to the visualizer.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int N         = N_DEF,
  parameter int MAG_DELAY = MAG_DELAY_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       sample_in,
  input  logic                   sample_valid,
  output logic                   fft_start,
  input  logic                   fft_done,
  output logic [N*WIDTH-1:0]     fft_samples,
  input  logic [N*(WIDTH+1)-1:0] fft_mag,
  output logic [N*(WIDTH+1)-1:0] mag_out,
  output logic                   mag_valid,
  input  logic                   mag_ready,
  output logic                   overrun,
  output logic                   fft_error,
  output logic [CNT_W-1:0]       frame_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = $clog2(MAG_DELAY + 1);

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N*(WIDTH+1)-1:0] mag_q;
  logic [CNT_W-1:0]       frm_q, drop_q;
  logic                   err_q, err_d;
  logic                   pending, drop;
  logic                   lock, rel, cap, hs;

  sample_pingpong #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_pp (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .lock_i       (lock),
    .release_i    (rel),
    .pending_o    (pending),
    .drop_o       (drop),
    .frame_o      (fft_samples)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    lock    = 1'b0;
    rel     = 1'b0;
    cap     = 1'b0;
    hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          lock    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fft_done) begin
          cnt_d   = CW'(MAG_DELAY);
          state_d = SETTLE;
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          // Abort: the locked frame is discarded.
          err_d   = 1'b1;
          rel     = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(1)) begin
          cap     = 1'b1;
          rel     = 1'b1;
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PRESENT: begin
        if (mag_ready) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mag_q   <= '0;
      frm_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (cap)
        mag_q <= fft_mag;
      if (hs)
        frm_q <= frm_q + CNT_W'(1);
      if (drop)
        drop_q <= sat_inc(drop_q);
    end
  end

  assign fft_start   = (state_q == START);
  assign mag_valid   = (state_q == PRESENT);
  assign mag_out     = mag_q;
  assign overrun     = drop;
  assign fft_error   = err_q;
  assign frame_count = frm_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a small FFT stand-in
// answering fft_start after a fixed latency.
module tb_fft_frame_ctrl;

  localparam int W  = 18;
  localparam int N  = 16;
  localparam int MW = W + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    sample_in;
  logic            sample_valid;
  logic            fft_start;
  logic            fft_done;
  logic [N*W-1:0]  fft_samples;
  logic [N*MW-1:0] fft_mag = '0;
  logic [N*MW-1:0] mag_out;
  logic            mag_valid;
  logic            mag_ready;
  logic            overrun;
  logic            fft_error;
  logic [15:0]     frame_count;
  logic [15:0]     drop_count;

  logic done_auto = 1'b0;
  logic done_man;
  logic fft_auto;
  int   ov_cnt = 0;
  int   start_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  assign fft_done = done_auto | done_man;

  fft_frame_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .fft_samples  (fft_samples),
    .fft_mag      (fft_mag),
    .mag_out      (mag_out),
    .mag_valid    (mag_valid),
    .mag_ready    (mag_ready),
    .overrun      (overrun),
    .fft_error    (fft_error),
    .frame_count  (frame_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun) ov_cnt++;
    if (fft_start) start_cnt++;
  end

  // FFT stand-in: done 3 cycles after start, magnitudes = sample+1000
  // only from the cycle after done (garbage before that).
  always @(negedge clk) begin
    if (fft_auto && fft_start && !rst) begin
      fft_mag = '1;
      repeat (3) @(negedge clk);
      done_auto = 1'b1;
      @(negedge clk);
      done_auto = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++)
        fft_mag[i*MW +: MW] = {1'b0, fft_samples[i*W +: W]} + MW'(1000);
    end
  end

  function automatic logic [N*W-1:0] frame_of(input int base);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  function automatic logic [N*MW-1:0] mag_of(input int base);
    logic [N*MW-1:0] v;
    for (int i = 0; i < N; i++) v[i*MW +: MW] = MW'(base + i + 1000);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    done_man = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input int base, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      sample_in = W'(base + k);
      sample_valid = 1'b1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (fft_start !== 1'b0) begin errors++;
      $display("FAIL rst_start: got %b want 0", fft_start); end
    checks++; if (mag_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mag_valid: got %b want 0", mag_valid); end
    checks++; if (overrun !== 1'b0) begin errors++;
      $display("FAIL rst_overrun: got %b want 0", overrun); end
    checks++; if (fft_error !== 1'b0) begin errors++;
      $display("FAIL rst_fft_error: got %b want 0", fft_error); end
    checks++; if (frame_count !== 16'd0) begin errors++;
      $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
    checks++; if (drop_count !== 16'd0) begin errors++;
      $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
    checks++; if (mag_out !== '0) begin errors++;
      $display("FAIL rst_mag_out: got %h want 0", mag_out); end
    checks++; if (fft_samples !== '0) begin errors++;
      $display("FAIL rst_fft_samples: got %h want 0", fft_samples); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fft_start !== 1'b0) begin errors++;
      $display("FAIL idle_start: got %b want 0", fft_start); end
  endtask

  task automatic test_single_frame();
    do_reset();
    fft_auto = 1'b1;
    mag_ready = 1'b1;
    send(0, 16);
    checks++; if (fft_start !== 1'b0) begin errors++;
      $display("FAIL sf_start_t0: got %b want 0", fft_start); end
    @(negedge clk);
    checks++; if (fft_start !== 1'b0) begin errors++;
      $display("FAIL sf_start_t1: got %b want 0", fft_start); end
    @(negedge clk);
    checks++; if (fft_start !== 1'b1) begin errors++;
      $display("FAIL sf_start_t2: got %b want 1", fft_start); end
    checks++; if (fft_samples !== frame_of(0)) begin errors++;
      $display("FAIL sf_samples: got %h want %h", fft_samples, frame_of(0)); end
    @(negedge clk);
    checks++; if (fft_start !== 1'b0) begin errors++;
      $display("FAIL sf_start_t3: got %b want 0", fft_start); end
    repeat (4) @(negedge clk);
    checks++; if (mag_valid !== 1'b0) begin errors++;
      $display("FAIL sf_valid_early: got %b want 0", mag_valid); end
    @(negedge clk);
    checks++; if (mag_valid !== 1'b1) begin errors++;
      $display("FAIL sf_valid: got %b want 1", mag_valid); end
    checks++; if (mag_out !== mag_of(0)) begin errors++;
      $display("FAIL sf_mag: got %h want %h", mag_out, mag_of(0)); end
    @(negedge clk);
    checks++; if (mag_valid !== 1'b0) begin errors++;
      $display("FAIL sf_valid_drop: got %b want 0", mag_valid); end
    checks++; if (frame_count !== 16'd1) begin errors++;
      $display("FAIL sf_frames: got %0d want 1", frame_count); end
  endtask

  task automatic test_back_to_back();
    int ov0, st0;
    do_reset();
    fft_auto = 1'b1;
    mag_ready = 1'b1;
    ov0 = ov_cnt;
    st0 = start_cnt;
    send(1000, 160);
    repeat (20) @(negedge clk);
    checks++; if (frame_count !== 16'd10) begin errors++;
      $display("FAIL b2b_frames: got %0d want 10", frame_count); end
    checks++; if (drop_count !== 16'd0) begin errors++;
      $display("FAIL b2b_drops: got %0d want 0", drop_count); end
    checks++; if (ov_cnt - ov0 != 0) begin errors++;
      $display("FAIL b2b_overrun: got %0d want 0", ov_cnt - ov0); end
    checks++; if (start_cnt - st0 != 10) begin errors++;
      $display("FAIL b2b_starts: got %0d want 10", start_cnt - st0); end
    checks++; if (mag_out !== mag_of(1144)) begin errors++;
      $display("FAIL b2b_last_mag: got %h want %h", mag_out, mag_of(1144)); end
  endtask

  task automatic test_backpressure();
    int k, ov0;
    do_reset();
    fft_auto = 1'b1;
    mag_ready = 1'b0;
    send(100, 16);
    k = 0;
    while (!mag_valid && k < 60) begin @(negedge clk); k++; end
    checks++; if (mag_valid !== 1'b1) begin errors++;
      $display("FAIL bp_first_valid: got %b want 1", mag_valid); end
    checks++; if (mag_out !== mag_of(100)) begin errors++;
      $display("FAIL bp_first_mag: got %h want %h", mag_out, mag_of(100)); end
    ov0 = ov_cnt;
    send(200, 40);
    repeat (3) @(negedge clk);
    checks++; if (ov_cnt - ov0 != 8) begin errors++;
      $display("FAIL bp_overrun: got %0d want 8", ov_cnt - ov0); end
    checks++; if (drop_count !== 16'd8) begin errors++;
      $display("FAIL bp_drops: got %0d want 8", drop_count); end
    checks++; if (mag_valid !== 1'b1) begin errors++;
      $display("FAIL bp_hold_valid: got %b want 1", mag_valid); end
    checks++; if (mag_out !== mag_of(100)) begin errors++;
      $display("FAIL bp_hold_mag: got %h want %h", mag_out, mag_of(100)); end
    checks++; if (frame_count !== 16'd0) begin errors++;
      $display("FAIL bp_hold_frames: got %0d want 0", frame_count); end
    mag_ready = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (frame_count !== 16'd3) begin errors++;
      $display("FAIL bp_frames: got %0d want 3", frame_count); end
    checks++; if (drop_count !== 16'd8) begin errors++;
      $display("FAIL bp_drops_end: got %0d want 8", drop_count); end
    checks++; if (mag_out !== mag_of(216)) begin errors++;
      $display("FAIL bp_last_mag: got %h want %h", mag_out, mag_of(216)); end
    checks++; if (mag_valid !== 1'b0) begin errors++;
      $display("FAIL bp_valid_end: got %b want 0", mag_valid); end
  endtask

  task automatic test_timeout();
    int s, k, j;
    do_reset();
    fft_auto = 1'b0;
    mag_ready = 1'b1;
    s = 0;
    k = 0;
    fork
      send(300, 32);
      begin
        while (!fft_start && s < 100) begin @(negedge clk); s++; end
        while (!fft_error && k < 100) begin @(negedge clk); k++; end
      end
    join
    checks++; if (s >= 100) begin errors++;
      $display("FAIL to_start: got none want fft_start"); end
    checks++; if (k != 65) begin errors++;
      $display("FAIL to_latency: got %0d want 65", k); end
    @(negedge clk);
    checks++; if (fft_error !== 1'b0) begin errors++;
      $display("FAIL to_pulse: got %b want 0", fft_error); end
    fft_auto = 1'b1;
    j = 0;
    while (!fft_start && j < 10) begin @(negedge clk); j++; end
    checks++; if (j >= 10) begin errors++;
      $display("FAIL to_next_start: got none want fft_start"); end
    checks++; if (fft_samples !== frame_of(316)) begin errors++;
      $display("FAIL to_next_frame: got %h want %h", fft_samples, frame_of(316)); end
    repeat (15) @(negedge clk);
    checks++; if (frame_count !== 16'd1) begin errors++;
      $display("FAIL to_frames: got %0d want 1", frame_count); end
    checks++; if (drop_count !== 16'd0) begin errors++;
      $display("FAIL to_drops: got %0d want 0", drop_count); end
  endtask

  task automatic test_reset_settle();
    int v, k;
    do_reset();
    fft_auto = 1'b1;
    mag_ready = 1'b1;
    send(500, 16);
    repeat (2) @(negedge clk);
    checks++; if (fft_start !== 1'b1) begin errors++;
      $display("FAIL rs_start: got %b want 1", fft_start); end
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (mag_out !== '0) begin errors++;
      $display("FAIL rs_mag_out: got %h want 0", mag_out); end
    checks++; if (fft_samples !== '0) begin errors++;
      $display("FAIL rs_samples: got %h want 0", fft_samples); end
    checks++; if ({fft_start, mag_valid, fft_error, overrun} !== 4'b0) begin
      errors++;
      $display("FAIL rs_flags: got %b want 0000",
               {fft_start, mag_valid, fft_error, overrun}); end
    checks++; if (frame_count !== 16'd0) begin errors++;
      $display("FAIL rs_frames: got %0d want 0", frame_count); end
    @(negedge clk);
    rst = 1'b0;
    v = 0;
    repeat (10) begin @(negedge clk); if (mag_valid) v++; end
    checks++; if (v != 0) begin errors++;
      $display("FAIL rs_no_valid: got %0d want 0", v); end
    send(600, 16);
    k = 0;
    while (!mag_valid && k < 20) begin @(negedge clk); k++; end
    checks++; if (mag_out !== mag_of(600)) begin errors++;
      $display("FAIL rs_fresh_mag: got %h want %h", mag_out, mag_of(600)); end
    @(negedge clk);
    checks++; if (frame_count !== 16'd1) begin errors++;
      $display("FAIL rs_fresh_frames: got %0d want 1", frame_count); end
  endtask

  task automatic test_spurious_done();
    do_reset();
    fft_auto = 1'b0;
    mag_ready = 1'b1;
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({fft_start, mag_valid, fft_error} !== 3'b0) begin errors++;
      $display("FAIL sp_idle: got %b want 000", {fft_start, mag_valid, fft_error}); end
    send(700, 16);
    repeat (2) @(negedge clk);
    checks++; if (fft_start !== 1'b1) begin errors++;
      $display("FAIL sp_start: got %b want 1", fft_start); end
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if ({mag_valid, fft_error} !== 2'b0) begin errors++;
      $display("FAIL sp_in_start: got %b want 00", {mag_valid, fft_error}); end
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    @(negedge clk);
    checks++; if (mag_valid !== 1'b0) begin errors++;
      $display("FAIL sp_settle: got %b want 0", mag_valid); end
    @(negedge clk);
    checks++; if (mag_valid !== 1'b1) begin errors++;
      $display("FAIL sp_valid: got %b want 1", mag_valid); end
    @(negedge clk);
    checks++; if (frame_count !== 16'd1) begin errors++;
      $display("FAIL sp_frames: got %0d want 1", frame_count); end
  endtask

  initial begin
    rst = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    done_man = 1'b0;
    fft_auto = 1'b0;
    mag_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_settle();
    test_spurious_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Frame sequencer in front of the 16-point radix-4 FFT core. It collects the audio sample stream into ping-pong frame buffers and pulses the FFT start. It waits for FFT done, lets the magnitude outputs settle, then registers the magnitudes and presents them to the visualizer with a valid/ready handshake. Capture continues during FFT processing; frames that cannot be buffered are dropped and counted.

Parameters:
WIDTH, 18, sample width (two's complement); FFT magnitude width is WIDTH+1
N, 16, points per frame; must equal the FFT core N
MAG_DELAY, 2, cycles after fft_done before fft_mag is valid (min 1)
TIMEOUT, 64, max cycles in WAIT_DONE before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_in  in  WIDTH  audio sample
sample_valid  in  1  sample_in valid this cycle
fft_start  out  1  one-cycle start pulse to FFT
fft_done  in  1  FFT done (single-cycle pulse)
fft_samples  out  N x WIDTH  locked frame to FFT time_samples
fft_mag  in  N x (WIDTH+1)  FFT magnitudes
mag_out  out  N x (WIDTH+1)  registered magnitude frame
mag_valid  out  1  mag_out valid
mag_ready  in  1  consumer accepts mag_out
overrun  out  1  one-cycle pulse per dropped sample
fft_error  out  1  one-cycle pulse on FFT timeout
frame_count  out  16  accepted frames, wraps
drop_count  out  16  dropped samples, saturates at 16'hFFFF

Behaviour:
- Reset (async assert): state IDLE; wr_bank=0, wr_ptr=0, both bank-full flags 0. All outputs 0, including mag_out, counts and fft_samples.
- Capture: sample_valid with write bank not full stores sample_in at [wr_bank][wr_ptr], then wr_ptr++. A write at wr_ptr=N-1 sets full[wr_bank] and wraps wr_ptr to 0.
- Swap: if full[wr_bank] and the other bank is free, wr_bank toggles on the next edge. The next sample goes to the new bank at index 0, so no sample is lost.
- If both banks are full (one locked by the FFT, one pending), incoming valid samples are dropped: overrun=1 that cycle and drop_count++.
- States:
  - IDLE: a full bank not being written → lock it (fft_bank), go to START.
  - START: fft_start=1 for exactly one cycle → WAIT_DONE; timer=0.
  - WAIT_DONE: on fft_done → SETTLE with cnt=MAG_DELAY. If timer reaches TIMEOUT-1 first → fft_error pulse, release fft_bank (frame discarded), go to IDLE. fft_done outside WAIT_DONE is ignored.
  - SETTLE: cnt-- each cycle. On the cycle cnt==1, mag_out<=fft_mag, release fft_bank (full cleared), go to PRESENT.
  - PRESENT: mag_valid=1. mag_valid&&mag_ready → mag_valid=0 next cycle, frame_count++, go to IDLE. mag_out stays stable while mag_valid=1.
- fft_samples is driven combinationally from bank fft_bank and stays stable from START through the SETTLE exit.
- Latency: the last-sample write at edge t gives fft_start high in cycle t+2. fft_done at edge d gives mag_valid high from edge d+MAG_DELAY.
- Simultaneous release and a full pending bank: the pending bank is locked from IDLE on the next cycle.
- Simultaneous capture completion and swap are handled in the same edge without loss.
- Reset mid-operation: immediate return to reset state. Any frame in progress, pending, or presented is discarded.
- Arithmetic: no arithmetic on samples. Counters are unsigned; drop_count saturates, frame_count wraps.

Decomposition:
- Package fft_ctrl_pkg holds: state_t enum {IDLE, START, WAIT_DONE, SETTLE, PRESENT}; default N, WIDTH, MAG_DELAY, TIMEOUT; count width constant 16.
- One sub-module, sample_pingpong: two N-entry banks, wr_ptr/wr_bank, full flags, and lock/release inputs. It outputs the pending/full status and the locked bank contents.
- fft_frame_ctrl holds the FSM, timers, mag register and counters.

Test Plan:
- 16 consecutive valid samples 0..15, fft_done 3 cycles after fft_start, mag_ready=1 → one fft_start pulse 2 cycles after the last write. fft_samples = 0..15. mag_valid 2 cycles after fft_done. frame_count=1.
- Continuous samples at 1/cycle, FFT done latency 3, mag_ready=1 → no overrun. Consecutive frames are processed back-to-back. drop_count=0 after 10 frames.
- mag_ready=0 held while 40 samples stream → frame 2 fills bank B and frame 3 overflows. overrun pulses 8 times, drop_count=8, and mag_out is unchanged until the handshake.
- fft_done never asserted → fft_error pulse exactly TIMEOUT cycles after WAIT_DONE entry. Return to IDLE, and the pending frame starts next.
- rst asserted asynchronously mid-SETTLE → all outputs 0 immediately, no mag_valid afterward. A fresh 16-sample frame processes normally.
- fft_done pulsed in IDLE/START → ignored; state and outputs unchanged.
